interrupt_controller: RTL

- Responder end of the INT_IRQ / INT_IACK / INT_IEND protocol driven by the screen processors (title, game, etc.).
- Generates a periodic frame-tick interrupt (code 0) and a keyboard interrupt (code 1).
- Presents one code at a time, holds the associated key byte on KBD_KEY, and waits for acknowledge and end-of-service before presenting the next interrupt.
- Sits between the keyboard decoder / frame timer and the currently enabled processor.

---
 rtl/int_pkg.sv | 13 +
 rtl/key_fifo.sv | 50 +++++
 rtl/interrupt_controller.sv | 108 ++++++++++
 3 files changed

// File: rtl/int_pkg.sv
// Shared interrupt codes and FSM state encoding for the screen-processor
// interrupt responder.
package int_pkg;

  localparam logic [1:0] IRQ_TICK = 2'd0;
  localparam logic [1:0] IRQ_KEY  = 2'd1;
  localparam logic [1:0] IRQ_NONE = 2'd3;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESENT = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO holding key bytes until the processor services them.
// dout always shows the head entry; storage is left unreset.
module key_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A push into a full FIFO still succeeds when the head leaves on the same edge.
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      count <= count + (AW+1)'(1);
      else if (pop_ok && !push_ok) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/interrupt_controller.sv
// Responder for the INT_IRQ/INT_IACK/INT_IEND handshake: presents frame ticks
// (code 0) and buffered key bytes (code 1) one at a time to the active processor.
module interrupt_controller
  import int_pkg::*;
#(
  parameter int TICK_DIV       = 833333,
  parameter int KEY_FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       KEY_VALID,
  input  logic [7:0] KEY_CODE,
  input  logic       INT_CLEAR,
  input  logic       INT_IACK,
  input  logic       INT_IEND,
  output logic [1:0] INT_IRQ,
  output logic [7:0] KBD_KEY,
  output logic       OVERRUN
);

  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] tick_cnt;
  logic             tick_wrap;
  logic             tick_pending;
  logic             tick_clr;
  logic [1:0]       state;
  logic             iack_ok;
  logic             fifo_pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [7:0]       fifo_head;

  // An abort in the same cycle as the acknowledge wins, so nothing is consumed.
  assign iack_ok   = (state == S_PRESENT) && INT_IACK && !INT_CLEAR;
  assign fifo_pop  = iack_ok && (INT_IRQ == IRQ_KEY);
  assign tick_clr  = iack_ok && (INT_IRQ == IRQ_TICK);
  assign tick_wrap = (tick_cnt == CNT_W'(TICK_DIV - 1));

  key_fifo #(
    .DEPTH  (KEY_FIFO_DEPTH),
    .DATA_W (8)
  ) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (KEY_VALID),
    .din   (KEY_CODE),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) tick_cnt <= '0;
    else        tick_cnt <= tick_wrap ? '0 : tick_cnt + CNT_W'(1);
  end

  // A wrap outranks the clear so a tick landing during acknowledge is kept.
  always_ff @(posedge CLK) begin
    if (!RESET)        tick_pending <= 1'b0;
    else if (tick_wrap) tick_pending <= 1'b1;
    else if (tick_clr)  tick_pending <= 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!RESET)                                  OVERRUN <= 1'b0;
    else if (KEY_VALID && fifo_full && !fifo_pop) OVERRUN <= 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state   <= S_IDLE;
      INT_IRQ <= IRQ_NONE;
      KBD_KEY <= 8'h00;
    end else if (INT_CLEAR) begin
      state   <= S_IDLE;
      INT_IRQ <= IRQ_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (tick_pending) begin
            state   <= S_PRESENT;
            INT_IRQ <= IRQ_TICK;
          end else if (!fifo_empty) begin
            state   <= S_PRESENT;
            INT_IRQ <= IRQ_KEY;
            KBD_KEY <= fifo_head;
          end
        end
        S_PRESENT: begin
          if (INT_IACK) begin
            state   <= S_SERVICE;
            INT_IRQ <= IRQ_NONE;
          end
        end
        S_SERVICE: begin
          if (INT_IEND) state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          INT_IRQ <= IRQ_NONE;
        end
      endcase
    end
  end

endmodule
